hcsr04_meas_ctrl: RTL

- Sequences one HC-SR04 ultrasonic measurement cycle: trigger pulse, echo capture, timeout and over-range checks, hold-off, then result hand-off.
- Converts the echo high time in microseconds to distance and presents it to the UART formatting path over a valid/ready handshake.
- Supports single-shot and free-running (periodic) modes.
- Sits between the sensor pins and the UART TX formatter.

---
 rtl/hcsr04_pkg.sv | 23 ++
 rtl/sync_edge_det.sv | 35 +++
 rtl/hcsr04_meas_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/hcsr04_pkg.sv
// hcsr04_pkg: shared state/status encodings, timing defaults and distance scaling
//   state_e  : measurement sequencer states
//   status_e : result status codes carried on dist_status
//   us_to_dist: echo microseconds -> distance in 0.01 mm units
package hcsr04_pkg;

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, HOLDOFF} state_e;
    typedef enum logic [1:0] {ST_OK = 2'b00, ST_NOECHO = 2'b01, ST_OVR = 2'b10} status_e;

    localparam int DIST_W         = 19;
    localparam int DIST_SCALE     = 17;
    localparam int TRIG_US_DEF    = 10;
    localparam int RISE_TO_US_DEF = 5000;
    localparam int MAX_US_DEF     = 30000;
    localparam int PERIOD_US_DEF  = 60000;
    localparam int CNT_W_DEF      = 16;

    // 17 = 16 + 1, so the scale is a single shift-and-add
    function automatic logic [DIST_W-1:0] us_to_dist(input logic [DIST_W-1:0] w);
        return (w << $clog2(DIST_SCALE - 1)) + w;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-FF synchronizer with registered rise/fall pulses for an async input
//   clk_i, rst_i : clock, synchronous active-high reset
//   async_i      : asynchronous input
//   level_o      : synchronized level
//   rise_o/fall_o: one-cycle pulses on synchronized edges
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // sh_q[1:0] is the synchronizer, sh_q[2] the previous synchronized level
    logic [2:0] sh_q;
    logic       rise_q, fall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_q   <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sh_q   <= {sh_q[1:0], async_i};
            rise_q <= sh_q[1] && !sh_q[2];
            fall_q <= !sh_q[1] && sh_q[2];
        end
    end

    assign level_o = sh_q[1];
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/hcsr04_meas_ctrl.sv
// hcsr04_meas_ctrl: HC-SR04 trigger/echo sequencer producing distance results over valid/ready
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   tick_us          : one-cycle strobe per microsecond
//   start, auto_en   : single-shot request, free-running enable
//   echo, trig       : sensor pins
//   dist_data/status/valid/ready : result handshake towards the UART formatter
//   busy             : high whenever the sequencer is not idle
module hcsr04_meas_ctrl
    import hcsr04_pkg::*;
#(
    parameter int TRIG_US    = TRIG_US_DEF,
    parameter int RISE_TO_US = RISE_TO_US_DEF,
    parameter int MAX_US     = MAX_US_DEF,
    parameter int PERIOD_US  = PERIOD_US_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              tick_us,
    input  logic              start,
    input  logic              auto_en,
    input  logic              echo,
    output logic              trig,
    output logic [DIST_W-1:0] dist_data,
    output logic [1:0]        dist_status,
    output logic              dist_valid,
    input  logic              dist_ready,
    output logic              busy
);

    logic              echo_s, echo_rise, echo_fall;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  width_q, period_q;
    logic              pending_q, trig_q, valid_q, busy_q, enter_trig;
    logic [DIST_W-1:0] data_q, data_d;
    logic [1:0]        status_q, status_d;

    sync_edge_det u_echo_sync (
        .clk_i  (sys_clk),
        .rst_i  (sys_rst),
        .async_i(echo),
        .level_o(echo_s),
        .rise_o (echo_rise),
        .fall_o (echo_fall)
    );

    assign enter_trig = (state_d == TRIG) && (state_q != TRIG);

    // The result is latched on the way into REPORT; REPORT itself raises valid.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        status_d = status_q;
        case (state_q)
            IDLE:      if ((pending_q || auto_en) && !echo_s) state_d = TRIG;
            TRIG:      if (tick_us && width_q == CNT_W'(TRIG_US - 1)) state_d = WAIT_RISE;
            WAIT_RISE: if (echo_rise) begin
                           state_d = MEASURE;
                       end else if (tick_us && width_q == CNT_W'(RISE_TO_US - 1)) begin
                           state_d  = REPORT;
                           status_d = ST_NOECHO;
                           data_d   = '0;
                       end
            // limit is checked first so a coincident fall resolves as over-range
            MEASURE:   if (tick_us && width_q == CNT_W'(MAX_US - 1)) begin
                           state_d  = REPORT;
                           status_d = ST_OVR;
                           data_d   = '0;
                       end else if (echo_fall) begin
                           state_d  = REPORT;
                           status_d = ST_OK;
                           data_d   = us_to_dist(DIST_W'(width_q));
                       end
            REPORT:    state_d = HOLDOFF;
            HOLDOFF:   if (period_q >= CNT_W'(PERIOD_US - 1) && !valid_q && !echo_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            width_q   <= '0;
            period_q  <= '0;
            pending_q <= 1'b0;
            trig_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            data_q    <= '0;
            status_q  <= ST_OK;
        end else begin
            state_q   <= state_d;
            width_q   <= (state_d != state_q) ? '0 : width_q + CNT_W'(tick_us);
            // saturates so a long back-pressure stall cannot wrap it below the period
            period_q  <= enter_trig ? '0 : period_q + CNT_W'(tick_us && !(&period_q));
            pending_q <= (pending_q && !enter_trig) || start;
            trig_q    <= state_d == TRIG;
            busy_q    <= state_d != IDLE;
            valid_q   <= (state_q == REPORT) || (valid_q && !dist_ready);
            data_q    <= data_d;
            status_q  <= status_d;
        end
    end

    assign trig        = trig_q;
    assign dist_data   = data_q;
    assign dist_status = status_q;
    assign dist_valid  = valid_q;
    assign busy        = busy_q;

endmodule
